gray_addsub_pipe: RTL and testbench

- Parametrised, pipelined successor to the 8-bit add/sub + binary-to-Gray block.
- Computes A+B or A-B on WIDTH-bit operands and converts the (WIDTH+1)-bit result {cout,sum} to Gray code.
- Adds an elastic valid/ready handshake with backpressure, an optional running accumulator (acc replaces A), and a signed-overflow flag.
- Sits between operand sources and the Gray-coded display/position logic in the lab datapath.

---
 rtl/gray_addsub_pipe.sv | 121 ++++++++++++
 tb/tb_gray_addsub_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_addsub_pipe.sv
// ============================================================================
// gray_addsub_pipe : 2-stage elastic add/sub with Gray-coded result + accum.
// Rev 1.0
// ============================================================================
`default_nettype none

module gray_addsub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   grayCode,
    output logic [WIDTH:0]   binOut,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam int MSB = WIDTH - 1;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH:0]   s1_res_q,   s1_res_d;
    logic             s1_ovf_q,   s1_ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   gray_q,     gray_d;
    logic [WIDTH:0]   bin_q,      bin_d;
    logic             ovf_q,      ovf_d;
    logic [WIDTH-1:0] acc_q,      acc_d;

    logic             w_adv1, w_adv2, w_in_xfer;
    logic [WIDTH-1:0] w_opa, w_opb;
    logic [WIDTH:0]   w_res;
    logic             w_ovf;

    assign w_adv2    = !out_valid_q || out_ready;
    assign w_adv1    = !s1_valid_q || w_adv2;
    assign w_in_xfer = in_valid && w_adv1;

    always_comb begin
        w_opa = acc_en ? acc_q : A;
        w_opb = mode ? ~B : B;
        w_res = {1'b0, w_opa} + {1'b0, w_opb} + {{WIDTH{1'b0}}, mode};
        w_ovf = (w_opa[MSB] == w_opb[MSB]) && (w_res[MSB] != w_opa[MSB]);
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_res_d    = s1_res_q;
        s1_ovf_d    = s1_ovf_q;
        out_valid_d = out_valid_q;
        gray_d      = gray_q;
        bin_d       = bin_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;

        // Operand data is only captured on a real transfer so idle inputs never leak in.
        if (w_adv1) begin
            s1_valid_d = w_in_xfer;
            if (w_in_xfer) begin
                s1_res_d = w_res;
                s1_ovf_d = w_ovf;
            end
        end

        if (w_adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                bin_d  = s1_res_q;
                gray_d = s1_res_q ^ (s1_res_q >> 1);
                ovf_d  = s1_ovf_q;
            end
        end

        // Clear wins over write-back; the current beat has already used the old value.
        if (acc_clr) begin
            acc_d = '0;
        end else if (w_in_xfer && acc_en) begin
            acc_d = w_res[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_res_q    <= '0;
            s1_ovf_q    <= 1'b0;
            out_valid_q <= 1'b0;
            gray_q      <= '0;
            bin_q       <= '0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_res_q    <= s1_res_d;
            s1_ovf_q    <= s1_ovf_d;
            out_valid_q <= out_valid_d;
            gray_q      <= gray_d;
            bin_q       <= bin_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
        end
    end

    assign in_ready  = w_adv1;
    assign out_valid = out_valid_q;
    assign grayCode  = gray_q;
    assign binOut    = bin_q;
    assign ovf       = ovf_q;
    assign acc       = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_addsub_pipe.sv
// ============================================================================
// tb_gray_addsub_pipe : scoreboard bench, directed edges plus random traffic.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gray_addsub_pipe;

    localparam int W = 8;

    typedef struct packed {
        logic       ovf;
        logic [W:0] gray;
        logic [W:0] bin;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic         mode, acc_en, acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   grayCode, binOut;
    logic         ovf;
    logic [W-1:0] acc;

    gray_addsub_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .mode(mode), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .grayCode(grayCode), .binOut(binOut), .ovf(ovf), .acc(acc)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    int           n_acc = 0;
    res_t         sb_q[$];
    res_t         got_q[$];
    logic [W-1:0] m_acc = '0;
    logic         held = 1'b0;
    res_t         held_v;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer and signed arithmetic on the operands.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        longint ua, ub, sa, sb, s, r, full, half;
        res_t   o;
        full = longint'(1) << W;
        half = longint'(1) << (W - 1);
        ua   = longint'(a);
        ub   = longint'(b);
        r    = m ? (ua + full - ub) : (ua + ub);
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        s    = m ? (sa - sb) : (sa + sb);
        o.bin  = r[W:0];
        o.gray = o.bin ^ (o.bin >> 1);
        o.ovf  = (s > half - 1) || (s < -half);
        return o;
    endfunction

    // Input-side monitor: runs after the output monitor in each cycle.
    always begin
        res_t   e;
        logic   xfer;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            sb_q.delete();
            m_acc = '0;
        end else begin
            chk("acc", 32'(acc), 32'(m_acc));
            chk("in_ready", 32'(in_ready), (sb_q.size() == 2 && !out_ready) ? 32'd0 : 32'd1);
            xfer = in_valid && in_ready;
            e = model(acc_en ? m_acc : A, B, mode);
            if (xfer) begin
                sb_q.push_back(e);
                n_acc++;
            end
            if (acc_clr)
                m_acc = '0;
            else if (xfer && acc_en)
                m_acc = e.bin[W-1:0];
        end
    end

    // Output monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_bin", 32'(binOut), 32'(held_v.bin));
                chk("hold_gray", 32'(grayCode), 32'(held_v.gray));
                chk("hold_ovf", 32'(ovf), 32'(held_v.ovf));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_beat: got bin %h expected no beat", binOut);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_bin", 32'(binOut), 32'(e.bin));
                    chk("sb_gray", 32'(grayCode), 32'(e.gray));
                    chk("sb_ovf", 32'(ovf), 32'(e.ovf));
                end
                got_q.push_back({ovf, grayCode, binOut});
            end
            held   = out_valid && !out_ready;
            held_v = {ovf, grayCode, binOut};
        end
    end

    // Called and returns just after a rising edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input logic ae);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        A = a; B = b; mode = m; acc_en = ae;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 30 && got_q.size() < n; i++) @(negedge clk);
        if (got_q.size() < n) begin
            n_vec++;
            n_err++;
            $display("FAIL out_timeout: got %0d beats expected %0d", got_q.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic m, input logic [W:0] eb, input logic [W:0] eg, input logic eo);
        got_q.delete();
        send(a, b, m, 1'b0);
        wait_got(1);
        if (got_q.size() >= 1) begin
            chk({nm, "_bin"}, 32'(got_q[0].bin), 32'(eb));
            chk({nm, "_gray"}, 32'(got_q[0].gray), 32'(eg));
            chk({nm, "_ovf"}, 32'(got_q[0].ovf), 32'(eo));
        end
    endtask

    initial begin
        int         base;
        logic [W:0] snap;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bin", 32'(binOut), 32'd0);
        chk("rst_gray", 32'(grayCode), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        run_vec("add", 8'h05, 8'h03, 1'b0, 9'h008, 9'h00C, 1'b0);
        run_vec("sub_pos", 8'h05, 8'h03, 1'b1, 9'h102, 9'h183, 1'b0);
        run_vec("sub_neg", 8'h03, 8'h05, 1'b1, 9'h0FE, 9'h081, 1'b0);
        run_vec("carry", 8'hFF, 8'h01, 1'b0, 9'h100, 9'h180, 1'b0);
        run_vec("ovf_add", 8'h7F, 8'h01, 1'b0, 9'h080, 9'h0C0, 1'b1);
        run_vec("ovf_sub", 8'h00, 8'h80, 1'b1, 9'h080, 9'h0C0, 1'b1);

        // Accumulator: clear, then three back-to-back increments.
        got_q.delete();
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        for (int i = 0; i < 3; i++) send(8'hAA, 8'h01, 1'b0, 1'b1);
        wait_got(3);
        if (got_q.size() >= 3) begin
            chk("acc_gray0", 32'(got_q[0].gray), 32'h001);
            chk("acc_gray1", 32'(got_q[1].gray), 32'h003);
            chk("acc_gray2", 32'(got_q[2].gray), 32'h002);
        end
        chk("acc_final", 32'(acc), 32'd3);

        // Backpressure: pipe fills after two beats and stalls the source.
        got_q.delete();
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                for (int i = 0; i < 4; i++) send(W'(8'h10 + i), 8'h01, 1'b0, 1'b0);
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_accepted", 32'(n_acc - base), 32'd2);
                snap = binOut;
                @(negedge clk);
                chk("bp_hold", 32'(binOut), 32'(snap));
                chk("bp_no_out", 32'(got_q.size()), 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_got(4);
        for (int i = 0; i < 4; i++)
            if (got_q.size() > i) chk("bp_order", 32'(got_q[i].bin), 32'h11 + 32'(i));

        // Reset with two beats in flight; acc is non-zero going in.
        got_q.delete();
        out_ready = 1'b0;
        send(8'h01, 8'h01, 1'b0, 1'b0);
        send(8'h02, 8'h02, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_acc", 32'(acc), 32'd0);
        chk("mid_rst_bin", 32'(binOut), 32'd0);
        chk("mid_rst_gray", 32'(grayCode), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale", 32'(got_q.size()), 32'd0);

        // Random traffic with random backpressure and accumulator use.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            A         = W'($urandom);
            B         = W'($urandom);
            mode      = 1'($urandom);
            acc_en    = ($urandom_range(0, 2) == 0);
            acc_clr   = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
